// File: rtl/mem_ctrl.sv
// Memory controller: routes datapath accesses to an external SRAM (with an ack
// timeout) or to memory-mapped keyboard/display registers at xFE00-xFE07.
module mem_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic        memEN,
   input  logic        memWE,
   output logic [15:0] mem_data,
   output logic        memR,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_wdata,
   output logic        sram_req,
   output logic        sram_we,
   input  logic [15:0] sram_rdata,
   input  logic        sram_ack,
   input  logic [7:0]  kb_data,
   input  logic        kb_valid,
   output logic [7:0]  disp_data,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic        bus_err,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SRAM = 2'd1;
   localparam logic [1:0] IO   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   // Handshake: memEN is held by the control unit until memR, which pulses for
   // exactly one cycle; the display side is valid/ready, transfer on valid&ready.
   logic [1:0]    state;
   logic [15:0]   addr_q;
   logic [15:0]   wdata_q;
   logic          we_q;
   logic [CW-1:0] wait_cnt;
   logic          kb_ready;
   logic [7:0]    kbdr;
   logic          is_io;
   logic          kbdr_rd_done;
   logic          ddr_wr;
   logic [15:0]   io_rdata;

   assign fsm_state  = state;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign is_io      = (MAR[15:3] == 13'h1FC0);

   assign kbdr_rd_done = (state == IO) && !we_q && (addr_q[2:0] == 3'd2);
   assign ddr_wr       = (state == IO) && we_q && (addr_q[2:0] == 3'd6);

   always_comb begin
      io_rdata = 16'h0000;
      case (addr_q[2:0])
         3'd0:    io_rdata = {kb_ready, 15'b0};
         3'd2:    io_rdata = {8'h00, kbdr};
         3'd4:    io_rdata = {~disp_valid, 15'b0};
         default: io_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         addr_q   <= 16'h0000;
         wdata_q  <= 16'h0000;
         we_q     <= 1'b0;
         wait_cnt <= '0;
         mem_data <= 16'h0000;
         memR     <= 1'b0;
         sram_req <= 1'b0;
         sram_we  <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (memEN) begin
                  addr_q   <= MAR;
                  wdata_q  <= MDR;
                  we_q     <= memWE;
                  wait_cnt <= '0;
                  if (is_io) begin
                     state <= IO;
                  end else begin
                     state    <= SRAM;
                     sram_req <= 1'b1;
                     sram_we  <= memWE;
                  end
               end
            end
            SRAM: begin
               if (sram_ack) begin
                  if (!we_q) mem_data <= sram_rdata;
                  sram_req <= 1'b0;
                  sram_we  <= 1'b0;
                  memR     <= 1'b1;
                  state    <= DONE;
               end else if (wait_cnt == LAST) begin
                  // No ack in time: abort with a recognisable poison value.
                  if (!we_q) mem_data <= 16'hDEAD;
                  sram_req <= 1'b0;
                  sram_we  <= 1'b0;
                  bus_err  <= 1'b1;
                  memR     <= 1'b1;
                  state    <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            IO: begin
               if (!we_q) mem_data <= io_rdata;
               memR  <= 1'b1;
               state <= DONE;
            end
            default: begin
               memR  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // A new keystroke beats the clear from a concurrent KBDR read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kb_ready <= 1'b0;
         kbdr     <= 8'h00;
      end else if (kb_valid) begin
         kbdr     <= kb_data;
         kb_ready <= 1'b1;
      end else if (kbdr_rd_done) begin
         kb_ready <= 1'b0;
      end
   end

   // A DDR write arriving while a character is still pending is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_valid <= 1'b0;
         disp_data  <= 8'h00;
      end else if (disp_valid && disp_ready) begin
         disp_valid <= 1'b0;
      end else if (ddr_wr && !disp_valid) begin
         disp_valid <= 1'b1;
         disp_data  <= wdata_q[7:0];
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table of SRAM/IO accesses plus hand-written
// keyboard, display, timeout and reset sequences.
module tb_mem_ctrl;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] MAR, MDR;
   logic        memEN, memWE;
   logic [15:0] mem_data;
   logic        memR;
   logic [15:0] sram_addr, sram_wdata;
   logic        sram_req, sram_we;
   logic [15:0] sram_rdata;
   logic        sram_ack;
   logic [7:0]  kb_data;
   logic        kb_valid;
   logic [7:0]  disp_data;
   logic        disp_valid;
   logic        disp_ready;
   logic        bus_err;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_data = 16'h0000;

   int ack_delay = 1;
   bit never_ack = 1'b0;
   int req_cnt = 0;

   mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .MAR(MAR), .MDR(MDR), .memEN(memEN), .memWE(memWE),
      .mem_data(mem_data), .memR(memR), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_req(sram_req), .sram_we(sram_we), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
      .kb_data(kb_data), .kb_valid(kb_valid), .disp_data(disp_data), .disp_valid(disp_valid),
      .disp_ready(disp_ready), .bus_err(bus_err), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // SRAM responder: raises ack for one cycle once req has been seen ack_delay times.
   always @(posedge clk) begin
      #1;
      if (sram_ack) begin
         sram_ack = 1'b0;
      end else if (sram_req) begin
         req_cnt = req_cnt + 1;
         if (!never_ack && req_cnt >= ack_delay) sram_ack = 1'b1;
      end else begin
         req_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_access(input logic [15:0] addr, input logic [15:0] data, input logic we,
                            input int exp_lat, input bit is_sram);
      int lat;
      bit got;
      logic [15:0] exp;
      @(negedge clk);
      MAR = addr; MDR = data; memWE = we; memEN = 1'b1;
      exp_q.push_back(model_data);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1 && is_sram) begin
            check("sram_req_on", {15'b0, sram_req}, 16'h0001);
            check("sram_addr", sram_addr, addr);
            check("sram_we", {15'b0, sram_we}, {15'b0, we});
            if (we) check("sram_wdata", sram_wdata, data);
         end
         if (memR) got = 1'b1;
      end
      memEN = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL memR_wait: no memR for addr %h within %0d cycles", addr, lat);
         void'(exp_q.pop_front());
      end else begin
         exp = exp_q.pop_front();
         check("mem_data", mem_data, exp);
         check("latency", 16'(lat), 16'(exp_lat));
         check("sram_req_off", {15'b0, sram_req}, 16'h0000);
         @(posedge clk); #1;
         check("memR_one_cycle", {15'b0, memR}, 16'h0000);
      end
   endtask

   // Reads update the model with the returned value; writes leave it unchanged.
   task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input int lat, input bit is_sram);
      model_data = exp;
      do_access(addr, 16'h0000, 1'b0, lat, is_sram);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data, input int lat, input bit is_sram);
      do_access(addr, data, 1'b1, lat, is_sram);
   endtask

   task automatic kb_pulse(input logic [7:0] ch);
      @(negedge clk);
      kb_data = ch; kb_valid = 1'b1;
      @(negedge clk);
      kb_valid = 1'b0;
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        we;
      int          delay;
      logic [15:0] rdata;
      logic [15:0] exp_data;
      int          lat;
      bit          is_sram;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{16'h3000, 16'h0000, 1'b0, 3, 16'h1234, 16'h1234, 4, 1'b1};
      vecs[1]  = '{16'h3001, 16'hBEEF, 1'b1, 2, 16'h9999, 16'h1234, 3, 1'b1};
      vecs[2]  = '{16'h4000, 16'h0000, 1'b0, 1, 16'hA5A5, 16'hA5A5, 2, 1'b1};
      vecs[3]  = '{16'hFE00, 16'h0000, 1'b0, 1, 16'h0000, 16'h0000, 2, 1'b0};
      vecs[4]  = '{16'hFE04, 16'h0000, 1'b0, 1, 16'h0000, 16'h8000, 2, 1'b0};
      vecs[5]  = '{16'hFE06, 16'h0000, 1'b0, 1, 16'h0000, 16'h0000, 2, 1'b0};
      vecs[6]  = '{16'hFE07, 16'h0000, 1'b0, 1, 16'h7777, 16'h0000, 2, 1'b0};
      vecs[7]  = '{16'hFE08, 16'h0000, 1'b0, 2, 16'h5555, 16'h5555, 3, 1'b1};
      vecs[8]  = '{16'hFDFF, 16'h0000, 1'b0, 1, 16'h1111, 16'h1111, 2, 1'b1};
      vecs[9]  = '{16'hFE00, 16'hFFFF, 1'b1, 1, 16'h0000, 16'h1111, 2, 1'b0};
      vecs[10] = '{16'hFE04, 16'hFFFF, 1'b1, 1, 16'h0000, 16'h1111, 2, 1'b0};

      reset = 1'b0; MAR = 0; MDR = 0; memEN = 0; memWE = 0;
      sram_rdata = 0; sram_ack = 0; kb_data = 0; kb_valid = 0; disp_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_memR", {15'b0, memR}, 16'h0000);
      check("rst_sram_req", {15'b0, sram_req}, 16'h0000);
      check("rst_mem_data", mem_data, 16'h0000);
      check("rst_bus_err", {15'b0, bus_err}, 16'h0000);
      check("rst_disp", {7'b0, disp_valid, disp_data}, 16'h0000);
      check("rst_state", {14'b0, fsm_state}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         ack_delay = vecs[i].delay;
         sram_rdata = vecs[i].rdata;
         if (!vecs[i].we) model_data = vecs[i].exp_data;
         do_access(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].lat, vecs[i].is_sram);
      end

      for (int i = 0; i < 4; i++) begin
         logic [15:0] a, d;
         int dl;
         a = 16'($urandom_range(0, 16'hFDFF));
         d = 16'($urandom_range(0, 16'hFFFF));
         dl = $urandom_range(1, 5);
         ack_delay = dl;
         sram_rdata = d;
         rd(a, d, dl + 1, 1'b1);
      end

      // Keyboard: ready flag, data, clear on KBDR read.
      kb_pulse(8'h41);
      rd(16'hFE00, 16'h8000, 2, 1'b0);
      rd(16'hFE02, 16'h0041, 2, 1'b0);
      rd(16'hFE00, 16'h0000, 2, 1'b0);

      // New keystroke lands on the same edge as a KBDR read completion.
      kb_pulse(8'h41);
      @(negedge clk);
      MAR = 16'hFE02; memWE = 1'b0; memEN = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kb_data = 8'h42; kb_valid = 1'b1;
      @(posedge clk); #1;
      memEN = 1'b0;
      check("kb_race_memR", {15'b0, memR}, 16'h0001);
      check("kb_race_data", mem_data, 16'h0041);
      @(negedge clk);
      kb_valid = 1'b0;
      model_data = 16'h0041;
      rd(16'hFE00, 16'h8000, 2, 1'b0);
      rd(16'hFE02, 16'h0042, 2, 1'b0);

      // Display: load, busy status, dropped second write, handshake.
      wr(16'hFE06, 16'h0058, 2, 1'b0);
      check("disp_data_load", {8'h00, disp_data}, 16'h0058);
      check("disp_valid_set", {15'b0, disp_valid}, 16'h0001);
      rd(16'hFE04, 16'h0000, 2, 1'b0);
      wr(16'hFE06, 16'h0059, 2, 1'b0);
      check("disp_data_drop", {8'h00, disp_data}, 16'h0058);
      @(negedge clk);
      disp_ready = 1'b1;
      @(posedge clk); #1;
      check("disp_valid_clr", {15'b0, disp_valid}, 16'h0000);
      @(negedge clk);
      disp_ready = 1'b0;
      rd(16'hFE04, 16'h8000, 2, 1'b0);

      // SRAM never acknowledges: timeout after TIMEOUT cycles in SRAM.
      never_ack = 1'b1;
      rd(16'h3100, 16'hDEAD, TIMEOUT + 1, 1'b1);
      check("bus_err_set", {15'b0, bus_err}, 16'h0001);
      never_ack = 1'b0;
      ack_delay = 2;
      sram_rdata = 16'h2468;
      rd(16'h3200, 16'h2468, 3, 1'b1);
      check("bus_err_sticky", {15'b0, bus_err}, 16'h0001);

      // Reset in the middle of an SRAM access.
      never_ack = 1'b1;
      @(negedge clk);
      MAR = 16'h3300; memWE = 1'b0; memEN = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_req", {15'b0, sram_req}, 16'h0000);
      check("mid_rst_memR", {15'b0, memR}, 16'h0000);
      check("mid_rst_state", {14'b0, fsm_state}, 16'h0000);
      check("mid_rst_bus_err", {15'b0, bus_err}, 16'h0000);
      memEN = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      never_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_memR", {15'b0, memR}, 16'h0000);
      model_data = 16'h0000;
      ack_delay = 1;
      sram_rdata = 16'h0F0F;
      rd(16'h3300, 16'h0F0F, 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

endmodule
